sent_rx_decoder: RTL and testbench
==================================

Name: sent_rx_decoder

Overview:
SENT (SAE J2716) receiver: recovers fast-channel frames from the single-wire `data_pulse` line driven by the team's SENT transmitter. It times falling-edge to falling-edge intervals in ticks, locks to the 56-tick sync pulse, and decodes the status, data and CRC nibbles. It checks the 4-bit CRC and assembles the short serial message (id 4 bit, data 8 bit) carried in status bits 3:2 over 16 frames. It sits at the loop-back/verification end of the SENT link, in the `clk` domain.

Parameters:
CLKS_PER_TICK, 300, clk cycles per SENT tick (3 us at 100 MHz); range 4..1023
NUM_DATA_NIBBLES, 6, data nibbles per frame; range 1..6
SYNC_TOL, 1, accepted sync deviation in ticks (56 ± SYNC_TOL)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
enable  input  1  decoder enable; 0 forces HUNT and suppresses all output pulses
data_pulse  input  1  SENT line, asynchronous to clk
frame_valid  output  1  one-cycle pulse: frame received, CRC correct
crc_error  output  1  one-cycle pulse: frame received, CRC wrong
nibble_error  output  1  one-cycle pulse: nibble interval outside 12..27 ticks
status_nibble  output  4  status of the last completed frame
data_nibbles  output  4*NUM_DATA_NIBBLES  data of the last completed frame; first nibble in MSBs
ss_valid  output  1  one-cycle pulse: short serial message complete, CRC correct
ss_id  output  4  short serial id
ss_data  output  8  short serial data

Behaviour:
- Reset: all outputs 0; FSM = HUNT; first_edge flag cleared; tick counter 0; short-serial bit count 0.
- Input path: 2-FF synchronizer, then falling-edge detect `fall` (sync2 prev = 1, now = 0).
- Timing:
  - On `fall`, the prescaler reloads to CLKS_PER_TICK/2. This rounds the interval to the nearest tick.
  - The 10-bit tick counter is captured as `ival`, then cleared.
  - The tick counter saturates at 1023.
  - The first `fall` after reset or after enable rises only starts timing; no interval is evaluated.
- FSM, evaluated on each `fall`:
  - HUNT: if `ival` is in [56-SYNC_TOL, 56+SYNC_TOL], go to STATUS and seed the CRC with 4'h5. Otherwise stay in HUNT, with no error. This covers the pause pulse and garbage.
  - STATUS: nibble = `ival` - 12; latch to a shadow register; go to DATA with index 0.
  - DATA: nibble = `ival` - 12; shift into the shadow data register; update the CRC; index++. When index = NUM_DATA_NIBBLES-1, go to CRC.
  - CRC: compute the final CRC and compare it with `ival` - 12.
    - On match: copy shadows to status_nibble/data_nibbles, pulse frame_valid, run the short-serial update.
    - On mismatch: pulse crc_error; outputs are unchanged.
    - In both cases go to HUNT. The next interval is either the sync pulse or the optional pause.
  - Any nibble state with `ival` < 12 or > 27: pulse nibble_error, go to HUNT, discard the shadow registers.
  - Saturated tick counter (1023) while not in HUNT: pulse nibble_error, go to HUNT.
- CRC (data nibbles only; status nibble excluded):
  - Per nibble: c = T[c] ^ nibble.
  - Final: crc = T[c].
  - T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
- Latency: output pulses and registered outputs are valid 3 clk after the data_pulse falling edge that ends the CRC nibble (2 sync + 1 decode).
- Short serial (on valid frames only):
  - Status bit3 = 1 resets the bit count to 0 and records bit2 as bit 0.
  - Otherwise bit2 is appended and the count increments.
  - At 16 bits, the 16-bit shift register holds id[15:12], data[11:4], crc[3:0].
  - crc is checked with the same CRC4 over the 3 id/data nibbles. Pass: update ss_id/ss_data and pulse ss_valid. Fail: discard silently.
  - A crc_error or nibble_error frame clears the bit count.
  - Bit3 = 1 arriving mid-message restarts the message.
- Simultaneous events: `fall` and tick saturation in the same cycle are resolved in favour of `fall`.
- Reset has priority over enable.
- enable low mid-frame: go to HUNT immediately; registered frame outputs are kept.

Decomposition:
- Package `sent_pkg`: FSM state enum (HUNT, STATUS, DATA, CRC), SYNC_TICKS = 56, NIB_MIN = 12, NIB_MAX = 27, CRC_SEED = 4'h5, CRC4 table function.
- Sub-module `sent_crc4`: combinational one-nibble CRC step (c_in, nibble → c_out). It is instantiated for the fast channel and reused for the short-serial check.

Test Plan:
All scenarios use CLKS_PER_TICK = 4.
- Sync 56, status 0, data all 0 (12 ticks each), CRC 5 (17 ticks) → frame_valid pulse; data_nibbles = 24'h000000; status_nibble = 0.
- Data 1,2,3,4,5,6, CRC 2 → frame_valid; data_nibbles = 24'h123456. The same frame with CRC 3 → crc_error; data_nibbles unchanged.
- Data nibble of 30 ticks mid-frame → nibble_error; the next correct frame decodes and frame_valid pulses.
- Back-to-back frames with a 100-tick pause between CRC and sync, plus a 54-tick pseudo-sync → pause ignored without error; 54 rejected; only valid frames pulse frame_valid.
- 16 valid frames carrying id = 4'h3, data = 8'hA5 and a correct short-serial CRC (bit3 = 1 in frame 0 only) → one ss_valid; ss_id = 3; ss_data = 8'hA5.
- reset asserted mid-DATA → all outputs 0, FSM in HUNT; the first frame after release decodes correctly.

Source files
------------

// File: rtl/sent_pkg.sv
// Shared types and constants for the SENT fast-channel receiver:
// decoder states, nibble timing limits and the CRC4 lookup table.
package sent_pkg;

  typedef enum logic [1:0] {
    HUNT,
    STATUS,
    DATA,
    CRC
  } state_t;

  localparam int SYNC_TICKS = 56;
  localparam int NIB_MIN = 12;
  localparam int NIB_MAX = 27;
  localparam logic [3:0] CRC_SEED = 4'h5;

  function automatic logic [3:0] crc4_tbl(input logic [3:0] idx);
    logic [3:0] r;
    case (idx)
      4'd0: r = 4'd0;
      4'd1: r = 4'd13;
      4'd2: r = 4'd7;
      4'd3: r = 4'd10;
      4'd4: r = 4'd14;
      4'd5: r = 4'd3;
      4'd6: r = 4'd9;
      4'd7: r = 4'd4;
      4'd8: r = 4'd1;
      4'd9: r = 4'd12;
      4'd10: r = 4'd6;
      4'd11: r = 4'd11;
      4'd12: r = 4'd15;
      4'd13: r = 4'd2;
      4'd14: r = 4'd8;
      default: r = 4'd5;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sent_crc4.sv
// One nibble step of the SENT CRC4; the final CRC is one more step with nibble 0.
module sent_crc4
  import sent_pkg::*;
(
  input  logic [3:0] c_in,
  input  logic [3:0] nibble,
  output logic [3:0] c_out
);

  assign c_out = crc4_tbl(c_in) ^ nibble;

endmodule

// File: rtl/sent_rx_decoder.sv
// SENT fast-channel receiver: times falling-edge intervals in ticks, locks to the
// sync pulse, decodes status/data/CRC nibbles and assembles the short serial message.
module sent_rx_decoder
  import sent_pkg::*;
#(
  parameter int CLKS_PER_TICK = 300,
  parameter int NUM_DATA_NIBBLES = 6,
  parameter int SYNC_TOL = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          data_pulse,
  output logic                          frame_valid,
  output logic                          crc_error,
  output logic                          nibble_error,
  output logic [3:0]                    status_nibble,
  output logic [4*NUM_DATA_NIBBLES-1:0] data_nibbles,
  output logic                          ss_valid,
  output logic [3:0]                    ss_id,
  output logic [7:0]                    ss_data
);

  localparam int DW = 4 * NUM_DATA_NIBBLES;

  logic          s1, s2, s3;
  logic          fall;
  logic [9:0]    presc;
  logic [9:0]    tick;
  logic          armed;
  state_t        state;
  logic [2:0]    idx;
  logic [3:0]    crc_c;
  logic [3:0]    stat_sh;
  logic [DW-1:0] data_sh;
  logic [15:0]   ss_sr;
  logic [4:0]    ss_cnt;

  logic [3:0]    nib;
  logic          nib_bad;
  logic          is_sync;
  logic          tick_sat;
  logic [3:0]    crc_nib_in;
  logic [3:0]    crc_next;

  logic [15:0]   ss_sr_n;
  logic [4:0]    ss_cnt_n;
  logic [3:0]    ss_c0, ss_c1, ss_c2, ss_c3;
  logic          ss_ok;

  assign fall = s3 & ~s2;
  // (tick - 12) mod 16 only needs the low nibble of the tick count
  assign nib = tick[3:0] - 4'hC;
  assign nib_bad = (tick < 10'(NIB_MIN)) || (tick > 10'(NIB_MAX));
  assign is_sync = (tick >= 10'(SYNC_TICKS - SYNC_TOL)) && (tick <= 10'(SYNC_TICKS + SYNC_TOL));
  assign tick_sat = (tick == 10'd1023);

  // In CRC state a zero nibble turns the running step into the final T[c]
  assign crc_nib_in = (state == DATA) ? nib : 4'd0;

  sent_crc4 u_crc_fast (.c_in(crc_c), .nibble(crc_nib_in), .c_out(crc_next));

  always_comb begin
    ss_sr_n = {ss_sr[14:0], stat_sh[2]};
    ss_cnt_n = ss_cnt + 5'd1;
    if (stat_sh[3]) begin
      ss_sr_n = {15'd0, stat_sh[2]};
      ss_cnt_n = 5'd1;
    end
  end

  sent_crc4 u_crc_ss0 (.c_in(CRC_SEED), .nibble(ss_sr_n[15:12]), .c_out(ss_c0));
  sent_crc4 u_crc_ss1 (.c_in(ss_c0), .nibble(ss_sr_n[11:8]), .c_out(ss_c1));
  sent_crc4 u_crc_ss2 (.c_in(ss_c1), .nibble(ss_sr_n[7:4]), .c_out(ss_c2));
  sent_crc4 u_crc_ss3 (.c_in(ss_c2), .nibble(4'd0), .c_out(ss_c3));

  assign ss_ok = (ss_c3 == ss_sr_n[3:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      presc <= '0;
      tick <= '0;
      armed <= 1'b0;
      state <= HUNT;
      idx <= '0;
      crc_c <= '0;
      stat_sh <= '0;
      data_sh <= '0;
      ss_sr <= '0;
      ss_cnt <= '0;
      frame_valid <= 1'b0;
      crc_error <= 1'b0;
      nibble_error <= 1'b0;
      status_nibble <= '0;
      data_nibbles <= '0;
      ss_valid <= 1'b0;
      ss_id <= '0;
      ss_data <= '0;
    end else begin
      s1 <= data_pulse;
      s2 <= s1;
      s3 <= s2;
      frame_valid <= 1'b0;
      crc_error <= 1'b0;
      nibble_error <= 1'b0;
      ss_valid <= 1'b0;

      // Half-tick reload on each edge rounds intervals to the nearest tick
      if (fall) begin
        presc <= 10'(CLKS_PER_TICK / 2);
        tick <= '0;
      end else if (presc == '0) begin
        presc <= 10'(CLKS_PER_TICK - 1);
        if (!tick_sat) tick <= tick + 10'd1;
      end else begin
        presc <= presc - 10'd1;
      end

      if (!enable) begin
        state <= HUNT;
        armed <= 1'b0;
      end else if (fall) begin
        if (!armed) begin
          armed <= 1'b1;
        end else begin
          case (state)
            HUNT: begin
              if (is_sync) begin
                state <= STATUS;
                crc_c <= CRC_SEED;
              end
            end
            STATUS: begin
              if (nib_bad) begin
                nibble_error <= 1'b1;
                ss_cnt <= '0;
                state <= HUNT;
              end else begin
                stat_sh <= nib;
                data_sh <= '0;
                idx <= '0;
                state <= DATA;
              end
            end
            DATA: begin
              if (nib_bad) begin
                nibble_error <= 1'b1;
                ss_cnt <= '0;
                state <= HUNT;
              end else begin
                data_sh <= (data_sh << 4) | DW'(nib);
                crc_c <= crc_next;
                if (idx == 3'(NUM_DATA_NIBBLES - 1)) state <= CRC;
                else idx <= idx + 3'd1;
              end
            end
            CRC: begin
              state <= HUNT;
              if (nib_bad) begin
                nibble_error <= 1'b1;
                ss_cnt <= '0;
              end else if (crc_next == nib) begin
                status_nibble <= stat_sh;
                data_nibbles <= data_sh;
                frame_valid <= 1'b1;
                if (ss_cnt_n == 5'd16) begin
                  ss_cnt <= '0;
                  if (ss_ok) begin
                    ss_id <= ss_sr_n[15:12];
                    ss_data <= ss_sr_n[11:4];
                    ss_valid <= 1'b1;
                  end
                end else begin
                  ss_cnt <= ss_cnt_n;
                  ss_sr <= ss_sr_n;
                end
              end else begin
                crc_error <= 1'b1;
                ss_cnt <= '0;
              end
            end
            default: state <= HUNT;
          endcase
        end
      end else if (tick_sat && state != HUNT) begin
        nibble_error <= 1'b1;
        ss_cnt <= '0;
        state <= HUNT;
      end
    end
  end

endmodule

// File: tb/tb_sent_rx_decoder.sv
// Directed bench for sent_rx_decoder: drives SENT frames tick-accurately and
// checks pulses, decoded fields and short-serial assembly against hand-computed values.
module tb_sent_rx_decoder;

  localparam int CPT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        data_pulse = 1'b1;
  logic        frame_valid;
  logic        crc_error;
  logic        nibble_error;
  logic [3:0]  status_nibble;
  logic [23:0] data_nibbles;
  logic        ss_valid;
  logic [3:0]  ss_id;
  logic [7:0]  ss_data;

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0;
  int ce_cnt = 0;
  int ne_cnt = 0;
  int ssv_cnt = 0;

  sent_rx_decoder #(
    .CLKS_PER_TICK(CPT),
    .NUM_DATA_NIBBLES(6),
    .SYNC_TOL(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .data_pulse(data_pulse),
    .frame_valid(frame_valid),
    .crc_error(crc_error),
    .nibble_error(nibble_error),
    .status_nibble(status_nibble),
    .data_nibbles(data_nibbles),
    .ss_valid(ss_valid),
    .ss_id(ss_id),
    .ss_data(ss_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (crc_error) ce_cnt++;
    if (nibble_error) ne_cnt++;
    if (ss_valid) ssv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One interval of n ticks: falling edge now, next falling edge n ticks later
  task automatic send_ival(input int n);
    data_pulse = 1'b0;
    repeat (2 * CPT) @(negedge clk);
    data_pulse = 1'b1;
    repeat ((n - 2) * CPT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] st, input logic [23:0] d, input logic [3:0] crc);
    send_ival(56);
    send_ival(12 + int'(st));
    for (int i = 0; i < 6; i++) send_ival(12 + int'(d[23 - 4 * i -: 4]));
    send_ival(12 + int'(crc));
  endtask

  logic [15:0] ss_msg;

  initial begin
    ss_msg = 16'h3A5A;
    repeat (5) @(negedge clk);

    // Reset state
    chk("rst_fv", frame_valid, 0);
    chk("rst_ce", crc_error, 0);
    chk("rst_ne", nibble_error, 0);
    chk("rst_ssv", ss_valid, 0);
    chk("rst_status", status_nibble, 0);
    chk("rst_data", data_nibbles, 0);
    chk("rst_ss_id", ss_id, 0);
    chk("rst_ss_data", ss_data, 0);
    chk("rst_state", 32'(dut.state), 32'(sent_pkg::HUNT));
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // All-zero frame, CRC 5, with a 3-cycle latency probe on the ending edge
    send_ival(20);
    send_frame(4'h0, 24'h000000, 4'h5);
    data_pulse = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("lat_cycle2_fv", frame_valid, 0);
    @(negedge clk);
    chk("lat_cycle3_fv", frame_valid, 1);
    repeat (5) @(negedge clk);
    data_pulse = 1'b1;
    repeat (20 * CPT - 8) @(negedge clk);
    chk("zero_fv_cnt", fv_cnt, 1);
    chk("zero_data", data_nibbles, 32'h000000);
    chk("zero_status", status_nibble, 0);

    // Data 123456: CRC 2 good, CRC 3 bad
    send_frame(4'h0, 24'h123456, 4'h2);
    send_ival(20);
    chk("d123456_fv_cnt", fv_cnt, 2);
    chk("d123456_data", data_nibbles, 32'h123456);
    send_frame(4'h0, 24'h123456, 4'h3);
    send_ival(20);
    chk("badcrc_ce_cnt", ce_cnt, 1);
    chk("badcrc_fv_cnt", fv_cnt, 2);
    chk("badcrc_data_kept", data_nibbles, 32'h123456);

    // 30-tick nibble aborts the frame; next frame decodes
    send_ival(56);
    send_ival(12);
    send_ival(13);
    send_ival(14);
    send_ival(30);
    send_ival(20);
    chk("longnib_ne_cnt", ne_cnt, 1);
    chk("longnib_fv_cnt", fv_cnt, 2);
    send_frame(4'h6, 24'hABCDEF, 4'h7);
    send_ival(20);
    chk("recover_fv_cnt", fv_cnt, 3);
    chk("recover_data", data_nibbles, 32'hABCDEF);
    chk("recover_status", status_nibble, 6);

    // 100-tick pause, 54-tick pseudo-sync with nibble-like tail, then real frame
    send_frame(4'h0, 24'h123456, 4'h2);
    send_ival(100);
    send_ival(54);
    send_ival(12);
    repeat (6) send_ival(13);
    send_ival(17);
    send_ival(20);
    chk("pseudo_fv_cnt", fv_cnt, 4);
    chk("pseudo_ne_cnt", ne_cnt, 1);
    chk("pseudo_ce_cnt", ce_cnt, 1);
    chk("pseudo_data", data_nibbles, 32'h123456);
    send_frame(4'h0, 24'h000000, 4'h5);
    send_ival(20);
    chk("after_pause_fv_cnt", fv_cnt, 5);
    chk("after_pause_data", data_nibbles, 32'h000000);

    // Short serial: id 3, data A5, crc A, MSB first, start bit in frame 0
    for (int f = 0; f < 16; f++) begin
      send_frame({(f == 0), ss_msg[15 - f], 2'b00}, 24'h000000, 4'h5);
      if (f == 15) begin
        data_pulse = 1'b0;
        repeat (2 * CPT) @(negedge clk);
        data_pulse = 1'b1;
        repeat (18 * CPT) @(negedge clk);
      end
      if (f == 14) begin
        send_ival(20);
        chk("ss_pending_ssv_cnt", ssv_cnt, 0);
      end
    end
    chk("ss_ssv_cnt", ssv_cnt, 1);
    chk("ss_id", ss_id, 4'h3);
    chk("ss_data", ss_data, 8'hA5);
    chk("ss_fv_cnt", fv_cnt, 21);

    // Reset in the middle of DATA
    send_ival(56);
    send_ival(12);
    data_pulse = 1'b0;
    repeat (2 * CPT) @(negedge clk);
    data_pulse = 1'b1;
    repeat (3 * CPT) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_state", 32'(dut.state), 32'(sent_pkg::HUNT));
    chk("midrst_ss_id", ss_id, 0);
    chk("midrst_ss_data", ss_data, 0);
    chk("midrst_fv", frame_valid, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    send_ival(20);
    send_frame(4'h0, 24'h123456, 4'h2);
    send_ival(20);
    chk("postrst_fv_cnt", fv_cnt, 22);
    chk("postrst_data", data_nibbles, 32'h123456);
    chk("postrst_ne_cnt", ne_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
